// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition encodings,
// NZCV bit positions and flag-write request bit positions.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction with the
// given condition field executes under the current NZCV flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      // The unused 1111 encoding behaves as always.
      COND_AL, COND_NV: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field on the
// pre-update flags and gates the PC, register, memory and flag write strobes.
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       no_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic [3:0] flags
);

  logic [1:0] nz;
  logic [1:0] cv;
  logic       cond_ex;

  assign flags = {nz, cv};

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ex (cond_ex)
  );

  assign pc_src    = pcs & cond_ex;
  assign reg_write = reg_w & cond_ex & ~no_write;
  assign mem_write = mem_w & cond_ex;

  // NZ and CV are written independently so logical ops can leave C/V intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      nz <= FLAGS_RST[3:2];
      cv <= FLAGS_RST[1:0];
    end else begin
      if (flag_w[FLAGW_NZ] && cond_ex) nz <= alu_flags[3:2];
      if (flag_w[FLAGW_CV] && cond_ex) cv <= alu_flags[1:0];
    end
  end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios, an all-condition sweep
// and randomized traffic against an architectural NZCV model.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs, reg_w, mem_w, no_write;
  logic       pc_src, reg_write, mem_write;
  logic [3:0] flags;

  logic [3:0] mflags;
  logic [3:0] exp_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;

  cond_logic #(.FLAGS_RST(4'b0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (alu_flags),
    .flag_w    (flag_w),
    .pcs       (pcs),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .no_write  (no_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .mem_write (mem_write),
    .flags     (flags)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Architectural reference: bits [3:1] pick a base test, bit 0 inverts it,
  // and 111x always executes.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    if (c[3:1] == 3'd7) return 1'b1;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  // Driver tasks
  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af,
                       input logic p, input logic rw, input logic mw, input logic nw);
    cond = c; flag_w = fw; alu_flags = af;
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    #1;
  endtask

  // Advances one clock; the scoreboard predicts the flags for that edge.
  task automatic step();
    logic [3:0] nxt, got;
    nxt = mflags;
    if (reset) nxt = 4'b0000;
    else begin
      if (flag_w[1] && ref_pass(cond, mflags)) nxt[3:2] = alu_flags[3:2];
      if (flag_w[0] && ref_pass(cond, mflags)) nxt[1:0] = alu_flags[1:0];
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    mflags = got;
    tests_run++;
    if (flags !== got) begin
      tests_failed++;
      $display("FAIL flags_after_edge: got %b expected %b", flags, got);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    drive(4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (pc_src !== 1'b0 || flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_eq: pc_src=%b flags=%b expected 0 / 0000", pc_src, flags);
    end
    drive(4'b0001, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (pc_src !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ne: pc_src=%b expected 1", pc_src);
    end
  endtask

  task automatic test_directed();
    // SUBS equal result, then EQ / NE consumers
    drive(4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (flags !== 4'b0100 || reg_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL eq_after_subs: flags=%b reg_write=%b expected 0100 / 1", flags, reg_write);
    end
    drive(4'b0001, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (reg_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL ne_after_subs: reg_write=%b expected 0", reg_write);
    end
    // LT on old flags while the same instruction clears them
    drive(4'b1110, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'b1011, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (mem_write !== 1'b1) begin
      tests_failed++;
      $display("FAIL lt_old_flags: mem_write=%b expected 1", mem_write);
    end
    step();
    // Failing EQ must suppress every side effect
    drive(4'b0000, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (pc_src !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL eq_fail_gating: pc=%b reg=%b mem=%b expected 000", pc_src, reg_write, mem_write);
    end
    step();
    // Independent NZ / CV groups
    drive(4'b1110, 2'b10, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (flags !== 4'b0100) begin
      tests_failed++;
      $display("FAIL nz_only: flags=%b expected 0100", flags);
    end
    drive(4'b1110, 2'b01, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    tests_run++;
    if (flags !== 4'b0111) begin
      tests_failed++;
      $display("FAIL cv_only: flags=%b expected 0111", flags);
    end
    // Reset beats flag write; outputs still use old flags during reset cycle
    drive(4'b1110, 2'b11, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    drive(4'b0000, 2'b11, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (pc_src !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_cycle_old_flags: pc_src=%b expected 1", pc_src);
    end
    step();
    reset = 1'b0;
    tests_run++;
    if (flags !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_priority: flags=%b expected 0000", flags);
    end
    // 1111 executes; no_write still blocks the register write
    drive(4'b1111, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (pc_src !== 1'b1 || reg_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL nv_no_write: pc=%b reg=%b expected 1 / 0", pc_src, reg_write);
    end
    // Unknown cond with no flag write leaves flags alone
    drive(4'b1110, 2'b11, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(4'bxxxx, 2'b00, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_all_conds();
    for (int f = 0; f < 16; f++) begin
      drive(4'b1110, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int c = 0; c < 16; c++) begin
        logic e;
        drive(4'(c), 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        e = ref_pass(4'(c), mflags);
        tests_run++;
        if (pc_src !== e || reg_write !== e || mem_write !== e) begin
          tests_failed++;
          $display("FAIL cond_sweep c=%b f=%b: pc=%b reg=%b mem=%b expected %b",
                   4'(c), mflags, pc_src, reg_write, mem_write, e);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic e;
      reset = ($urandom_range(0, 19) == 0);
      drive(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      e = ref_pass(cond, mflags);
      tests_run++;
      if (pc_src !== (pcs && e) || reg_write !== (reg_w && e && !no_write) ||
          mem_write !== (mem_w && e)) begin
        tests_failed++;
        $display("FAIL random_outputs i=%0d cond=%b flags=%b: pc=%b reg=%b mem=%b",
                 i, cond, mflags, pc_src, reg_write, mem_write);
      end
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    mflags = 4'b0000;
    reset = 1'b0;
    test_reset();
    test_directed();
    test_all_conds();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
